serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial N-bit adder controller that drives one adder_1bit instance.
//  Loads two N-bit operands on a start pulse and presents one bit pair per clock, LSB first.
//  Registers the carry between bits and reassembles the sum.
//  Flags completion with a one-cycle done pulse to the consuming datapath.
// PARAMETERS
//  NUM_BITS  8  operand/result width; legal range 2..32
// PORTS
//  clk        in   1         system clock, rising edge
//  n_rst      in   1         asynchronous active-low reset
//  start      in   1         request; sampled only in IDLE or DONE
//  a          in   NUM_BITS  operand A, captured on accepted start
//  b          in   NUM_BITS  operand B, captured on accepted start
//  carry_in   in   1         initial carry, captured on accepted start
//  busy       out  1         high while in RUN
//  done       out  1         one-cycle pulse on completion
//  sum        out  NUM_BITS  registered result, held until next completion
//  carry_out  out  1         registered final carry, held with sum
//  overflow   out  1         signed overflow; present only with OVERFLOW_EN
// BEHAVIOUR
//  Reset (n_rst=0, async):
//   - state=IDLE; busy, done, sum, carry_out, overflow all 0.
//   - Internal shift registers, carry register and counter all 0.
//  FSM states:
//   - IDLE -> RUN on start=1.
//   - RUN: stays while cnt<NUM_BITS-1; -> DONE on the edge that processes bit NUM_BITS-1.
//   - DONE -> RUN if start=1 (back-to-back); otherwise -> IDLE.
//  Accept edge (start=1 in IDLE/DONE):
//   - a_sr<=a, b_sr<=b, c_reg<=carry_in, cnt<=0, sum_sr<=0.
//  RUN, each edge:
//   - adder_1bit gets a_sr[0], b_sr[0], c_reg.
//   - sum_sr<={s,sum_sr[N-1:1]}; a_sr/b_sr shift right by 1.
//   - c_reg<=cout; cnt<=cnt+1.
//   - cnt width is $clog2(NUM_BITS).
//  Completion (final RUN edge):
//   - sum<={s,sum_sr[N-1:1]}; carry_out<=cout.
//   - Output registers update only on this edge.
//  Latency:
//   - Start accepted at edge 0; bits processed on edges 1..NUM_BITS.
//   - done=1 for the cycle after edge NUM_BITS.
//   - busy=1 from after edge 0 to edge NUM_BITS.
//  Boundary cases:
//   - start in RUN is ignored; operands are not re-sampled.
//   - Input changes in RUN have no effect.
//   - Reset mid-RUN aborts: no done pulse, outputs return to 0.
//   - Arithmetic is modulo 2^NUM_BITS; carry_out carries bit NUM_BITS.
// CONFIGURATION
//  OVERFLOW_EN defined:
//   - Adds overflow port.
//   - overflow = carry into MSB XOR carry out of MSB.
//   - Latched with sum; reset value 0.
//  OVERFLOW_EN undefined:
//   - Port and logic absent; all other behaviour identical.
// STRUCTURE
//  Package serial_adder_pkg:
//   - typedef enum logic [1:0] {IDLE, RUN, DONE} sadd_state_t.
//   - localparam DEFAULT_NUM_BITS = 8.
//  Sub-module:
//   - One adder_1bit instance (u_fa) as the combinational bit slice.
//   - FSM, shift registers and counter live in this module.
// TESTING  (NUM_BITS=8)
//  1. a=0x0F, b=0x01, cin=0, start 1 cycle
//     -> sum=0x10, carry_out=0; done exactly 8 edges after accept, 1 cycle wide.
//  2. a=0xFF, b=0x00, cin=1 -> sum=0x00, carry_out=1.
//  3. a=0x7F, b=0x01, OVERFLOW_EN
//     -> sum=0x80, overflow=1, carry_out=0.
//  4. start pulsed at cycle 3 of RUN with new operands
//     -> ignored; result matches first operands.
//  5. n_rst=0 at cycle 4 of RUN -> no done; all outputs 0; IDLE.
//     Next start completes normally.
//  6. start held high through DONE with a=0x01, b=0x02
//     -> second op starts without IDLE; sum=0x03 after its done.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sadd_state_t;

  localparam int DEFAULT_NUM_BITS = 8;

endpackage

// File: rtl/adder_1bit.sv
// Combinational full-adder bit slice used by the serial adder controller.
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial NUM_BITS adder controller: LSB-first through one full-adder slice.
// Optional signed overflow output is enabled by defining OVERFLOW_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] sum,
  output logic                carry_out
`ifdef OVERFLOW_EN
  ,
  output logic                overflow
`endif
);

  localparam int CW = $clog2(NUM_BITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_BITS - 1);

  sadd_state_t         state_q, state_d;
  logic [NUM_BITS-1:0] a_sr_q, a_sr_d;
  logic [NUM_BITS-1:0] b_sr_q, b_sr_d;
  logic [NUM_BITS-1:0] sum_sr_q, sum_sr_d;
  logic [NUM_BITS-1:0] sum_q, sum_d;
  logic                c_q, c_d;
  logic                cout_q, cout_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                fa_s, fa_cout;
  logic [NUM_BITS-1:0] sum_shift;

  adder_1bit u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB; after NUM_BITS shifts the LSB lines up at bit 0.
  assign sum_shift = {fa_s, sum_sr_q[NUM_BITS-1:1]};

  // Bit 0 of the partial-sum register is always shifted out before use.
  logic unused_sum_lsb;
  assign unused_sum_lsb = sum_sr_q[0];

`ifdef OVERFLOW_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    c_d      = c_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
`ifdef OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          a_sr_d   = a;
          b_sr_d   = b;
          c_d      = carry_in;
          cnt_d    = '0;
          sum_sr_d = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = sum_shift;
        c_d      = fa_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          sum_d   = sum_shift;
          cout_d  = fa_cout;
`ifdef OVERFLOW_EN
          // c_q is the carry into the MSB on this final edge.
          ovf_d   = c_q ^ fa_cout;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
`ifdef OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
`ifdef OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (NUM_BITS=8); define OVERFLOW_EN to also check overflow.
module tb_serial_adder_ctrl;

  localparam int N = 8;

  logic         clk;
  logic         n_rst;
  logic         start;
  logic [N-1:0] a, b;
  logic         carry_in;
  logic         busy, done, carry_out;
  logic [N-1:0] sum;
`ifdef OVERFLOW_EN
  logic         overflow;
`endif

  serial_adder_ctrl #(.NUM_BITS(N)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs [8];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_ovf(input string name, input logic exp);
`ifdef OVERFLOW_EN
    chk(name, 32'(overflow), 32'(exp));
`else
    if (exp === 1'bx) $display("[TB] %s unused", name);
`endif
  endtask

  // Waits (bounded) for done; returns edges counted since the accept edge.
  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
    end
  endtask

  // Launch one op and leave the bench at the negedge after the accept edge.
  task automatic launch(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc);
    @(negedge clk);
    a = va; b = vb; carry_in = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~va; b = ~vb; carry_in = ~vc;
  endtask

  task automatic check_result(input string tag, input int cyc, input vec_t v);
    chk({tag, "_latency"}, 32'(cyc), 32'(N));
    chk({tag, "_sum"}, 32'(sum), 32'(v.sum));
    chk({tag, "_cout"}, 32'(carry_out), 32'(v.cout));
    chk_ovf({tag, "_ovf"}, v.ovf);
    $display("[TB] %s a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d lat=%0d",
             tag, v.a, v.b, v.cin, sum, carry_out, cyc);
  endtask

  initial begin
    int   cyc;
    int   saw_done;
    vec_t v;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

    n_rst = 1'b0; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(carry_out), 32'd0);
    chk_ovf("rst_ovf", 1'b0);
    n_rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].cin);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      wait_done(0, cyc);
      check_result($sformatf("v%0d", i), cyc, vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_done_width", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_busy_after", i), 32'(busy), 32'd0);
    end

    // start during RUN with new operands must be ignored
    launch(8'h0F, 8'h01, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'h55; b = 8'h55; carry_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, cyc);
    check_result("run_start_ignored", cyc, vecs[0]);

    // reset mid-RUN aborts with no done pulse and cleared outputs
    launch(8'h21, 8'h11, 1'b0);
    repeat (4) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(carry_out), 32'd0);
    chk_ovf("abort_ovf", 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    saw_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) saw_done++;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    $display("[TB] abort mid-run: sum=%02h busy=%0d", sum, busy);
    launch(vecs[5].a, vecs[5].b, vecs[5].cin);
    wait_done(0, cyc);
    check_result("after_abort", cyc, vecs[5]);

    // back-to-back: start held high through DONE
    @(negedge clk);
    a = 8'h10; b = 8'h20; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h01; b = 8'h02;
    v = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    wait_done(0, cyc);
    check_result("b2b_first", cyc, v);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_rerun_busy", 32'(busy), 32'd1);
    chk("b2b_rerun_done", 32'(done), 32'd0);
    v = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
    wait_done(0, cyc);
    check_result("b2b_second", cyc, v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
